pwm_breathe_sequencer: RTL and testbench



---
 rtl/pwm_seq_pkg.sv | 22 ++
 rtl/pwm_rr_arbiter.sv | 42 ++++
 rtl/pwm_breathe_sequencer.sv | 162 ++++++++++++++++
 tb/tb_pwm_breathe_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_seq_pkg.sv
// Shared constants, types and index helpers for the breathing-LED PWM sequencer.
// Used by pwm_breathe_sequencer and its testbench.
package pwm_seq_pkg;

  localparam int TABLE_LEN = 100;
  localparam int DUTY_W    = 6;
  localparam int IDX_W     = $clog2(TABLE_LEN);

  typedef logic [DUTY_W-1:0] duty_t;
  typedef logic [IDX_W-1:0]  idx_t;

  // Phase index advance, wrapping at the end of the sine table.
  function automatic idx_t next_index(input idx_t idx);
    return (idx == idx_t'(TABLE_LEN - 1)) ? '0 : idx + idx_t'(1);
  endfunction

  // Channels start evenly spread around the table so they breathe out of step.
  function automatic idx_t phase_offset(input int k, input int num_ch);
    return idx_t'((k * TABLE_LEN) / num_ch);
  endfunction

endpackage

// File: rtl/pwm_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the rotating pointer,
// then moves the pointer just past the winner.
module pwm_rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] grant,
  output logic              grant_valid
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] cand;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_idx   = ptr;
    cand        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = PTR_W'((int'(ptr) + i) % NUM_CH);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_idx == PTR_W'(NUM_CH - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/pwm_breathe_sequencer.sv
// Multi-channel breathing-LED duty sequencer sharing one sine-table ROM.
// Optional macro PWMSEQ_OVERRUN_EN adds a sticky per-channel 'overrun' output.
module pwm_breathe_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH-1:0]        ch_static,
  input  logic [DUTY_W-1:0]        static_duty,
  input  logic [DIV_W-1:0]         tick_div,
  output logic                     rom_rd,
  output logic [IDX_W-1:0]         rom_addr,
  input  logic [DUTY_W-1:0]        rom_data,
  output logic [NUM_CH*DUTY_W-1:0] duty,
  output logic [NUM_CH-1:0]        duty_upd,
`ifdef PWMSEQ_OVERRUN_EN
  output logic [NUM_CH-1:0]        overrun,
`endif
  output logic                     busy
);

  logic [DIV_W-1:0]  presc;
  logic              tick;
  logic [NUM_CH-1:0] active;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant;
  logic              grant_valid;
  idx_t              grant_addr;
  idx_t              index [NUM_CH];
  logic [NUM_CH-1:0] rd_ch;
  logic              cap_vld;
  logic [NUM_CH-1:0] cap_ch;
  logic [NUM_CH-1:0] wr_ch;
  duty_t             duty_r [NUM_CH];

  assign active = ch_en & ~ch_static;
  assign tick   = (presc == tick_div);
  assign req    = pending & active;
  assign busy   = (|pending) | rom_rd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
    end else begin
      presc <= tick ? '0 : presc + DIV_W'(1);
    end
  end

  // A tick re-arms the request even if the channel is granted on the same edge,
  // so the freshly advanced index is always fetched eventually.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        index[k] <= phase_offset(k, NUM_CH);
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (tick && active[k]) begin
          index[k] <= next_index(index[k]);
        end
        if (!active[k]) begin
          pending[k] <= 1'b0;
        end else if (tick) begin
          pending[k] <= 1'b1;
        end else if (grant[k]) begin
          pending[k] <= 1'b0;
        end
      end
    end
  end

  pwm_rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .grant      (grant),
    .grant_valid(grant_valid)
  );

  always_comb begin
    grant_addr = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant[k]) begin
        grant_addr = index[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_rd   <= 1'b0;
      rom_addr <= '0;
      rd_ch    <= '0;
      cap_vld  <= 1'b0;
      cap_ch   <= '0;
    end else begin
      rom_rd  <= grant_valid;
      rd_ch   <= grant;
      if (grant_valid) begin
        rom_addr <= grant_addr;
      end
      cap_vld <= rom_rd & (|(rd_ch & active));
      cap_ch  <= rd_ch;
    end
  end

  // Reads whose channel went disabled or static while in flight are dropped here.
  assign wr_ch = cap_vld ? (cap_ch & active) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_upd <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        duty_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        duty_upd[k] <= 1'b0;
        if (!ch_en[k]) begin
          duty_r[k] <= '0;
        end else if (ch_static[k]) begin
          duty_r[k] <= static_duty;
        end else if (wr_ch[k]) begin
          duty_r[k]   <= rom_data;
          duty_upd[k] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    duty = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      duty[k*DUTY_W +: DUTY_W] = duty_r[k];
    end
  end

`ifdef PWMSEQ_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!ch_en[k]) begin
          overrun[k] <= 1'b0;
        end else if (tick && active[k] && pending[k]) begin
          overrun[k] <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_pwm_breathe_sequencer.sv
// Testbench for pwm_breathe_sequencer: transaction-level reference model with a
// random-content ROM, directed phases and randomized enable/static traffic.
module tb_pwm_breathe_sequencer;
  import pwm_seq_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 16;

  typedef struct {
    int ch;
    int addr;
    int due;
  } rd_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_CH-1:0]        ch_en;
  logic [NUM_CH-1:0]        ch_static;
  logic [DUTY_W-1:0]        static_duty;
  logic [DIV_W-1:0]         tick_div;
  logic                     rom_rd;
  logic [IDX_W-1:0]         rom_addr;
  logic [DUTY_W-1:0]        rom_data;
  logic [NUM_CH*DUTY_W-1:0] duty;
  logic [NUM_CH-1:0]        duty_upd;
  logic                     busy;
`ifdef PWMSEQ_OVERRUN_EN
  logic [NUM_CH-1:0]        overrun;
`endif

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   rom_tbl [TABLE_LEN];
  int   m_idx [NUM_CH];
  int   m_duty [NUM_CH];
  bit   m_pend [NUM_CH];
  bit   m_upd [NUM_CH];
  bit   m_ovr [NUM_CH];
  int   m_ptr, m_cnt, m_addr, m_gch;
  bit   m_rd;
  rd_t  inflight [$];
  int   addr_q [$];
  int   exp_first [4] = '{1, 26, 51, 76};
  logic prev_rd;
  logic [IDX_W-1:0] prev_addr;
  bit   found;

  always #5 clk = ~clk;

  pwm_breathe_sequencer #(
    .NUM_CH(NUM_CH),
    .DIV_W (DIV_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch_en      (ch_en),
    .ch_static  (ch_static),
    .static_duty(static_duty),
    .tick_div   (tick_div),
    .rom_rd     (rom_rd),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .duty       (duty),
    .duty_upd   (duty_upd),
`ifdef PWMSEQ_OVERRUN_EN
    .overrun    (overrun),
`endif
    .busy       (busy)
  );

  task automatic resetModel();
    for (int k = 0; k < NUM_CH; k++) begin
      m_idx[k]  = (k * TABLE_LEN) / NUM_CH;
      m_duty[k] = 0;
      m_pend[k] = 1'b0;
      m_upd[k]  = 1'b0;
      m_ovr[k]  = 1'b0;
    end
    m_ptr = 0;
    m_cnt = 0;
    m_rd  = 1'b0;
    m_gch = -1;
    inflight.delete();
  endtask

  // Advances the reference model across one clock edge using this cycle's inputs.
  task automatic modelStep();
    bit  act [NUM_CH];
    bit  tick;
    int  g;
    rd_t keep [$];
    if (!rst_n) begin
      resetModel();
      return;
    end
    for (int k = 0; k < NUM_CH; k++) act[k] = ch_en[k] && !ch_static[k];
    tick = (m_cnt == int'(tick_div));
    foreach (inflight[i]) if (act[inflight[i].ch]) keep.push_back(inflight[i]);
    inflight = keep;
    for (int k = 0; k < NUM_CH; k++) begin
      m_upd[k] = 1'b0;
      if (!ch_en[k]) m_duty[k] = 0;
      else if (ch_static[k]) m_duty[k] = int'(static_duty);
    end
    keep.delete();
    foreach (inflight[i]) begin
      if (inflight[i].due == cyc) begin
        m_duty[inflight[i].ch] = rom_tbl[inflight[i].addr];
        m_upd[inflight[i].ch]  = 1'b1;
      end else begin
        keep.push_back(inflight[i]);
      end
    end
    inflight = keep;
    g = -1;
    for (int i = 0; i < NUM_CH; i++) begin
      int c;
      c = (m_ptr + i) % NUM_CH;
      if (g < 0 && m_pend[c] && act[c]) g = c;
    end
    m_rd  = (g >= 0);
    m_gch = g;
    if (g >= 0) begin
      m_addr = m_idx[g];
      inflight.push_back('{g, m_idx[g], cyc + 2});
      m_ptr = (g + 1) % NUM_CH;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (!ch_en[k]) m_ovr[k] = 1'b0;
      else if (tick && act[k] && m_pend[k]) m_ovr[k] = 1'b1;
      if (!act[k]) m_pend[k] = 1'b0;
      else if (tick) m_pend[k] = 1'b1;
      else if (k == g) m_pend[k] = 1'b0;
      if (tick && act[k]) m_idx[k] = (m_idx[k] + 1) % TABLE_LEN;
    end
    m_cnt = tick ? 0 : (m_cnt + 1) % (1 << DIV_W);
  endtask

  // The ROM registers the address on the rom_rd cycle and returns data the cycle after.
  task automatic stepCycle();
    modelStep();
    prev_rd   = rom_rd;
    prev_addr = rom_addr;
    @(posedge clk);
    #1;
    if (prev_rd && int'(prev_addr) < TABLE_LEN) rom_data = DUTY_W'(rom_tbl[prev_addr]);
    else rom_data = DUTY_W'($urandom);
    cyc++;
  endtask

  task automatic checkOutput(input string tag);
    logic [NUM_CH*DUTY_W-1:0] e_duty;
    logic [NUM_CH-1:0]        e_upd;
    logic [NUM_CH-1:0]        e_ovr;
    logic                     e_busy;
    e_duty = '0;
    e_upd  = '0;
    e_ovr  = '0;
    e_busy = m_rd;
    for (int k = 0; k < NUM_CH; k++) begin
      e_duty[k*DUTY_W +: DUTY_W] = DUTY_W'(m_duty[k]);
      e_upd[k] = m_upd[k];
      e_ovr[k] = m_ovr[k];
      if (m_pend[k]) e_busy = 1'b1;
    end
    checks++;
    assert (rom_rd === m_rd) else begin
      errors++;
      $error("[TB] FAIL %s rom_rd cyc=%0d observed=%b expected=%b", tag, cyc, rom_rd, m_rd);
    end
    if (m_rd) begin
      checks++;
      assert (rom_addr === IDX_W'(m_addr)) else begin
        errors++;
        $error("[TB] FAIL %s rom_addr cyc=%0d observed=%0d expected=%0d", tag, cyc, rom_addr, m_addr);
      end
    end
    checks++;
    assert (duty === e_duty) else begin
      errors++;
      $error("[TB] FAIL %s duty cyc=%0d observed=%h expected=%h", tag, cyc, duty, e_duty);
    end
    checks++;
    assert (duty_upd === e_upd) else begin
      errors++;
      $error("[TB] FAIL %s duty_upd cyc=%0d observed=%b expected=%b", tag, cyc, duty_upd, e_upd);
    end
    checks++;
    assert (busy === e_busy) else begin
      errors++;
      $error("[TB] FAIL %s busy cyc=%0d observed=%b expected=%b", tag, cyc, busy, e_busy);
    end
`ifdef PWMSEQ_OVERRUN_EN
    checks++;
    assert (overrun === e_ovr) else begin
      errors++;
      $error("[TB] FAIL %s overrun cyc=%0d observed=%b expected=%b", tag, cyc, overrun, e_ovr);
    end
`endif
  endtask

  task automatic applyStimulus(input logic rst, input logic [NUM_CH-1:0] en,
                               input logic [NUM_CH-1:0] st, input logic [DUTY_W-1:0] sd,
                               input logic [DIV_W-1:0] td);
    rst_n       = rst;
    ch_en       = en;
    ch_static   = st;
    static_duty = sd;
    tick_div    = td;
  endtask

  task automatic runCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      stepCycle();
      checkOutput(tag);
    end
  endtask

  initial begin
    rom_data = '0;
    for (int i = 0; i < TABLE_LEN; i++) rom_tbl[i] = int'($urandom_range(0, 63));
    resetModel();

    // Phase 1: reset values, then the first tick fetches 1/26/51/76 in channel order.
    applyStimulus(1'b0, 4'hF, 4'h0, 6'h00, 16'd9);
    runCycles(3, "reset");
    checks++;
    assert (duty === '0) else begin
      errors++;
      $error("[TB] FAIL reset_duty observed=%h expected=0", duty);
    end
    applyStimulus(1'b1, 4'hF, 4'h0, 6'h00, 16'd9);
    for (int i = 0; i < 15; i++) begin
      runCycles(1, "first_tick");
      if (rom_rd) addr_q.push_back(int'(rom_addr));
    end
    checks++;
    assert (addr_q.size() == 4) else begin
      errors++;
      $error("[TB] FAIL first_tick_reads observed=%0d expected=4", addr_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      int got;
      got = (i < addr_q.size()) ? addr_q[i] : -1;
      checks++;
      assert (got == exp_first[i]) else begin
        errors++;
        $error("[TB] FAIL first_tick_addr%0d observed=%0d expected=%0d", i, got, exp_first[i]);
      end
    end
    runCycles(30, "breathe4");

    // Phase 2: channel 0 alone walks the whole table and wraps.
    for (int i = 0; i < TABLE_LEN; i++) rom_tbl[i] = i % 64;
    applyStimulus(1'b0, 4'h1, 4'h0, 6'h00, 16'd9);
    runCycles(2, "wrap_rst");
    applyStimulus(1'b1, 4'h1, 4'h0, 6'h00, 16'd9);
    runCycles(1030, "wrap");

    // Phase 3: ticks faster than the arbiter can service four channels.
    for (int i = 0; i < TABLE_LEN; i++) rom_tbl[i] = int'($urandom_range(0, 63));
    applyStimulus(1'b0, 4'hF, 4'h0, 6'h00, 16'd1);
    runCycles(2, "ovr_rst");
    applyStimulus(1'b1, 4'hF, 4'h0, 6'h00, 16'd1);
    runCycles(60, "overrun");

    // Phase 4: disable channel 2 while its read is in flight, then re-enable.
    applyStimulus(1'b0, 4'hF, 4'h0, 6'h00, 16'd9);
    runCycles(2, "dis_rst");
    applyStimulus(1'b1, 4'hF, 4'h0, 6'h00, 16'd9);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      runCycles(1, "dis_wait");
      if (m_rd && m_gch == 2) found = 1'b1;
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("[TB] FAIL dis_grant_timeout observed=0 expected=1");
    end
    applyStimulus(1'b1, 4'hB, 4'h0, 6'h00, 16'd9);
    runCycles(35, "disabled");
    applyStimulus(1'b1, 4'hF, 4'h0, 6'h00, 16'd9);
    runCycles(35, "reenable");

    // Phase 5: channels 0 and 2 static, 1 and 3 still breathing.
    applyStimulus(1'b1, 4'hF, 4'b0101, 6'h2A, 16'd9);
    runCycles(50, "static");

    // Phase 6: randomized enable/static/duty traffic at a fast tick rate.
    applyStimulus(1'b0, 4'hF, 4'h0, 6'h00, 16'd3);
    runCycles(2, "rand_rst");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b1, NUM_CH'($urandom), NUM_CH'($urandom & $urandom),
                    DUTY_W'($urandom), 16'd3);
      runCycles(int'($urandom_range(1, 12)), "random");
    end

    // Phase 7: reset while a read is on the bus aborts it cleanly.
    applyStimulus(1'b1, 4'hF, 4'h0, 6'h00, 16'd3);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      runCycles(1, "abort_wait");
      if (m_rd) found = 1'b1;
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("[TB] FAIL abort_rd_timeout observed=0 expected=1");
    end
    applyStimulus(1'b0, 4'hF, 4'h0, 6'h00, 16'd3);
    runCycles(1, "abort");
    applyStimulus(1'b1, 4'hF, 4'h0, 6'h00, 16'd3);
    runCycles(4, "abort_after");
    checks++;
    assert (duty_upd === '0) else begin
      errors++;
      $error("[TB] FAIL abort_upd observed=%b expected=0", duty_upd);
    end
    runCycles(20, "abort_resume");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
